// File: rtl/spi_rx_fifo.sv
// SPI peripheral receiver: oversampled sck/sdi/cs, word assembly, and a valid/ready read FIFO.
// Optional transmit path (sdo, tx_data, tx_load) is enabled by defining SPI_RX_TX_EN.
module spi_rx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sck,
  input  logic                     sdi,
  input  logic                     cs,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SPI_RX_TX_EN
  ,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_load,
  output logic                     sdo
`endif
);

  localparam int   AW          = $clog2(DEPTH);
  localparam int   CNTW        = AW + 1;
  localparam int   CW          = $clog2(WIDTH);
  localparam logic SCK_IDLE    = (CPOL != 0);
  localparam bit   SAMPLE_RISE = (CPOL == CPHA);

  // Read handshake: a word moves when rd_valid && rd_ready at a rising clk edge;
  // rd_valid never depends on rd_ready and rd_data holds while rd_valid && !rd_ready.

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic sck_s1_q, sck_s2_q, sck_h_q;
  logic sdi_s1_q, sdi_s2_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic sck_rise, sck_fall, sample_edge, cs_rise, cs_fall;
  logic push, do_push, drop, pop, full;
  logic [WIDTH-1:0] word_next;

  assign sck_rise    = sck_s2_q & ~sck_h_q;
  assign sck_fall    = ~sck_s2_q & sck_h_q;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign cs_rise     = cs_s2_q & ~cs_h_q;
  assign cs_fall     = ~cs_s2_q & cs_h_q;

  always_comb begin
    if (MSB_FIRST != 0) word_next = {shift_q[WIDTH-2:0], sdi_s2_q};
    else                word_next = {sdi_s2_q, shift_q[WIDTH-1:1]};
  end

  // Frame FSM; a cs fall wins over a coincident sample edge.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          shift_d       = '0;
        end
      end
      ACTIVE: begin
        if (cs_fall) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          frame_err_d  = (bit_cnt_q != '0);
          bit_cnt_d    = '0;
        end else if (sample_edge) begin
          shift_d = word_next;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            push      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
  assign full    = (count_q == CNTW'(DEPTH));
  assign pop     = (count_q != '0) && rd_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = word_next;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !pop)      count_d = count_q + CNTW'(1);
    else if (!do_push && pop) count_d = count_q - CNTW'(1);
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q      <= SCK_IDLE;
      sck_s2_q      <= SCK_IDLE;
      sck_h_q       <= SCK_IDLE;
      sdi_s1_q      <= 1'b0;
      sdi_s2_q      <= 1'b0;
      cs_s1_q       <= 1'b0;
      cs_s2_q       <= 1'b0;
      cs_h_q        <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sck_s1_q      <= sck;
      sck_s2_q      <= sck_s1_q;
      sck_h_q       <= sck_s2_q;
      sdi_s1_q      <= sdi;
      sdi_s2_q      <= sdi_s1_q;
      cs_s1_q       <= cs;
      cs_s2_q       <= cs_s1_q;
      cs_h_q        <= cs_s2_q;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign rd_valid    = (count_q != '0);
  assign fifo_count  = count_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

`ifdef SPI_RX_TX_EN
  logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             launch_edge;

  assign launch_edge = SAMPLE_RISE ? sck_fall : sck_rise;

  // A launch edge at bit 0 starts a fresh word, otherwise it advances one bit.
  always_comb begin
    tx_hold_d = tx_load ? tx_data : tx_hold_q;
    tx_sh_d   = tx_sh_q;
    if (state_q == IDLE) begin
      if (cs_rise) tx_sh_d = tx_hold_d;
    end else if (!cs_fall && launch_edge) begin
      if (bit_cnt_q == '0)     tx_sh_d = tx_hold_d;
      else if (MSB_FIRST != 0) tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
      else                     tx_sh_d = {1'b0, tx_sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold_q <= '0;
      tx_sh_q   <= '0;
    end else begin
      tx_hold_q <= tx_hold_d;
      tx_sh_q   <= tx_sh_d;
    end
  end

  assign sdo = (state_q == ACTIVE) &&
               ((MSB_FIRST != 0) ? tx_sh_q[WIDTH-1] : tx_sh_q[0]);
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: four instances (SPI modes 0..3, alternating bit order) share one
// SPI bus; expected words are queued at stimulus time and checked by a read monitor.
module tb_spi_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck0 = 1'b0;
  logic       sckn;
  logic       sdi = 1'b0;
  logic       cs = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_ready = 4'h0;

  logic [7:0] rd_data [4];
  logic [2:0] fifo_count [4];
  logic [3:0] rd_valid, frame_start, frame_done, frame_err, overflow;

  int checks = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         idx [4];
  int         n_start [4];
  int         n_done [4];
  int         n_err [4];
  int         n_err_alone [4];
  int         exp_start = 0;
  int         exp_done = 0;
  int         exp_err = 0;

  assign sckn = ~sck0;

  always #5 clk = ~clk;

  // g: mode g; CPOL = g/2, CPHA = g%2; even instances MSB-first, odd LSB-first.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_rx_fifo #(
      .WIDTH(8), .DEPTH(4), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1 - (g % 2))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sck        ((g / 2) != 0 ? sckn : sck0),
      .sdi        (sdi),
      .cs         (cs),
      .rd_data    (rd_data[g]),
      .rd_valid   (rd_valid[g]),
      .rd_ready   (rd_ready[g]),
      .frame_start(frame_start[g]),
      .frame_done (frame_done[g]),
      .frame_err  (frame_err[g]),
      .overflow   (overflow[g]),
      .ovf_clr    (ovf_clr),
      .fifo_count (fifo_count[g])
    );
  end

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Read monitor: every accepted word is compared with the next queued expectation.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rst_n && rd_valid[g] && rd_ready[g]) begin
        if (idx[g] >= exp_q.size()) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word dut%0d: got 0x%0h with no word expected", g, rd_data[g]);
        end else begin
          check("rd_data", g, 32'(rd_data[g]),
                32'((g % 2) != 0 ? bitrev(exp_q[idx[g]]) : exp_q[idx[g]]));
        end
        idx[g]++;
      end
      if (frame_start[g]) n_start[g]++;
      if (frame_done[g]) n_done[g]++;
      if (frame_err[g] && frame_done[g]) n_err[g]++;
      if (frame_err[g] && !frame_done[g]) n_err_alone[g]++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One bit: data settles while sck0 is low; rising samplers (0,2) and falling samplers
  // (1,3) may get a one-cycle rd_ready pulse aligned with their push cycle.
  task automatic send_bit(input logic b, input logic pulse);
    sdi = b;
    wait_clk(4);
    sck0 = 1'b1;
    wait_clk(2);
    if (pulse) rd_ready = rd_ready | 4'b0101;
    wait_clk(1);
    if (pulse) rd_ready = rd_ready & 4'b1010;
    wait_clk(1);
    sck0 = 1'b0;
    wait_clk(2);
    if (pulse) rd_ready = rd_ready | 4'b1010;
    wait_clk(1);
    if (pulse) rd_ready = rd_ready & 4'b0101;
    wait_clk(1);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic pulse_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], pulse_last && (i == 0));
  endtask

  task automatic frame_begin();
    cs = 1'b1;
    exp_start++;
    wait_clk(4);
  endtask

  task automatic frame_end(input logic partial);
    wait_clk(4);
    cs = 1'b0;
    exp_done++;
    if (partial) exp_err++;
    wait_clk(6);
  endtask

  task automatic drain(input int n);
    rd_ready = 4'hF;
    wait_clk(n);
    rd_ready = 4'h0;
    wait_clk(1);
  endtask

  task automatic check_all(input string name, input int cnt, input logic ovf);
    for (int g = 0; g < 4; g++) begin
      check({name, "_count"}, g, 32'(fifo_count[g]), 32'(cnt));
      check({name, "_valid"}, g, 32'(rd_valid[g]), 32'(cnt != 0));
      check({name, "_overflow"}, g, 32'(overflow[g]), 32'(ovf));
    end
  endtask

  task automatic check_frames(input string name);
    for (int g = 0; g < 4; g++) begin
      check({name, "_starts"}, g, 32'(n_start[g]), 32'(exp_start));
      check({name, "_dones"}, g, 32'(n_done[g]), 32'(exp_done));
      check({name, "_errs"}, g, 32'(n_err[g]), 32'(exp_err));
    end
  endtask

  task automatic check_reset(input string name);
    for (int g = 0; g < 4; g++) begin
      check({name, "_rd_data"}, g, 32'(rd_data[g]), 32'h0);
      check({name, "_flags"}, g,
            32'({rd_valid[g], frame_start[g], frame_done[g], frame_err[g], overflow[g]}), 32'h0);
      check({name, "_count"}, g, 32'(fifo_count[g]), 32'h0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 4; g++) begin
      idx[g] = 0; n_start[g] = 0; n_done[g] = 0; n_err[g] = 0; n_err_alone[g] = 0;
    end
    wait_clk(3);
    check_reset("reset");
    rst_n = 1'b1;
    wait_clk(3);

    // Single word 0xA5.
    exp_q.push_back(8'hA5);
    frame_begin();
    send_byte(8'hA5, 1'b0);
    frame_end(1'b0);
    check_all("a5_held", 1, 1'b0);
    check_frames("a5");
    drain(4);
    check_all("a5_drained", 0, 1'b0);

    // Single word 0x3C, then two back-to-back words in one frame.
    exp_q.push_back(8'h3C);
    frame_begin();
    send_byte(8'h3C, 1'b0);
    frame_end(1'b0);
    drain(4);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hF0);
    frame_begin();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hF0, 1'b0);
    frame_end(1'b0);
    check_all("b2b_held", 2, 1'b0);
    drain(6);

    // Burst of 5 with no reads: fifth word dropped, overflow set, then cleared.
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    frame_begin();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    frame_end(1'b0);
    check_all("burst_full", 4, 1'b1);
    ovf_clr = 1'b1;
    wait_clk(1);
    ovf_clr = 1'b0;
    drain(8);
    check_all("burst_drained", 0, 1'b0);

    // Burst of 5 with a read exactly on the fifth push: nothing dropped.
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    frame_begin();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    frame_end(1'b0);
    check_all("pushpop_full", 4, 1'b0);
    drain(10);
    check_all("pushpop_drained", 0, 1'b0);

    // Partial frame: 0xC3 then 3 stray bits.
    exp_q.push_back(8'hC3);
    frame_begin();
    send_byte(8'hC3, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    frame_end(1'b1);
    check_all("partial_held", 1, 1'b0);
    check_frames("partial");
    drain(4);

    // Reset in the middle of a frame, then a clean frame 0x7E.
    frame_begin();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    cs = 1'b0;
    wait_clk(2);
    check_reset("mid_reset");
    rst_n = 1'b1;
    wait_clk(4);
    exp_q.push_back(8'h7E);
    frame_begin();
    send_byte(8'h7E, 1'b0);
    frame_end(1'b0);
    check_all("post_reset_held", 1, 1'b0);
    drain(4);
    check_all("post_reset_drained", 0, 1'b0);
    check_frames("final");

    for (int g = 0; g < 4; g++) begin
      check("words_read", g, 32'(idx[g]), 32'(exp_q.size()));
      check("err_without_done", g, 32'(n_err_alone[g]), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
